// File: rtl/seradd_pkg.sv
// Shared definitions for the serial nibble adder: nibble width, FSM encoding
// and the index-width helper.
package seradd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble index width; a single-nibble adder still needs one index bit.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/four_ripple.sv
// 4-bit ripple-carry adder: the shared nibble datapath fed by
// serial_nibble_adder.
module four_ripple (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    always_comb begin
        logic [4:0] c;
        c     = '0;
        o_sum = '0;
        c[0]  = i_cin;
        for (int i = 0; i < 4; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
            c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = c[4];
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that serialises operands one nibble per clock
// through four_ripple. Optional signed-overflow output: SERADD_OVF_EN.
module serial_nibble_adder
    import seradd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("serial_nibble_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_e               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
`ifdef SERADD_OVF_EN
    logic                 r_ovf;
`endif

    logic [NIBBLE_W-1:0]  w_a_nib;
    logic [NIBBLE_W-1:0]  w_b_nib;
    logic [NIBBLE_W-1:0]  w_nib_sum;
    logic                 w_nib_cout;
    logic                 w_accept;
    logic                 w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERADD_OVF_EN
    assign ovf       = r_ovf;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_nib  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    four_ripple u_nibble (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // Operand capture: only loaded on accept, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Control FSM and registered results. The only carry path between
    // nibbles is r_carry, so each clock adds exactly one nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
                    r_carry <= w_nib_cout;
                    if (w_last) begin
                        r_cout  <= w_nib_cout;
`ifdef SERADD_OVF_EN
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_nib_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
`endif
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_carry <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder (WIDTH=16); overflow vectors are
// included when SERADD_OVF_EN is defined.
module tb_serial_nibble_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERADD_OVF_EN
    logic             ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    serial_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERADD_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compare each new result against the oldest expected entry.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
`ifdef SERADD_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.o));
`endif
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s; e.c = c; e.o = o;
        exp_q.push_back(e);
    endtask

    // One full transaction with out_ready high; checks accept-to-valid latency.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
        int lat;
        push_exp(es, ec, eo);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NIB));
        @(negedge clk);
    endtask

    initial begin
        int first, second, w;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back max-with-carry operations: accept-to-accept spacing.
        push_exp(16'hFFFF, 1'b1, 1'b0);
        push_exp(16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        first = -1; second = -1;
        for (int c = 0; c < 30 && second < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (in_ready) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        chk("accept_spacing", 32'(second - first), 32'(NIB + 2));
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        chk("idle_after_b2b", 32'(in_ready), 32'd1);

        // Backpressure with in_valid held high.
        push_exp(16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!out_valid && w < 20);
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_sum_stable", 32'(sum), 32'h1000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of RUN; the aborted operation has no result.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef SERADD_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
